// File: rtl/led_sequencer_if.sv
// Control and pattern signals between the LED sequencer and the logic that drives it.
interface led_sequencer_if #(
    parameter int WIDTH = 18
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] pins;
    logic             tick;

    modport master (output en, output mode, input pins, input tick);
    modport slave  (input en, input mode, output pins, output tick);
endinterface

// File: rtl/led_sequencer.sv
// LED pattern generator: a prescaler produces a step tick, and the pattern advances as
// rotate up, rotate down, bounce, or binary count on every tick.
module led_sequencer #(
    parameter int WIDTH = 18,
    parameter int DIV   = 500000
) (
    input logic           clk,
    input logic           rst_n,
    led_sequencer_if.slave bus
);
    localparam int             CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [WIDTH-1:0] LSB_HOT = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_HOT = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pins_q, pins_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;

    function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
        case (m)
            2'd1:    seed = MSB_HOT;
            2'd3:    seed = '0;
            default: seed = LSB_HOT;
        endcase
    endfunction

    always_comb begin
        cnt_d  = cnt_q;
        pins_d = pins_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        // A mode change reseeds even when disabled and beats a step due on the same edge.
        if (bus.mode != mode_q) begin
            mode_d = bus.mode;
            pins_d = seed(bus.mode);
            cnt_d  = '0;
            dir_d  = DIR_UP;
        end else if (bus.en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                case (mode_q)
                    2'd0: pins_d = pins_q[WIDTH-1] ? LSB_HOT : (pins_q << 1);
                    2'd1: pins_d = pins_q[0] ? MSB_HOT : (pins_q >> 1);
                    2'd2: begin
                        // Turning at an endpoint moves away immediately, so no endpoint repeats.
                        if (dir_q == DIR_UP) begin
                            if (pins_q[WIDTH-1]) begin
                                dir_d  = DIR_DOWN;
                                pins_d = pins_q >> 1;
                            end else begin
                                pins_d = pins_q << 1;
                            end
                        end else begin
                            if (pins_q[0]) begin
                                dir_d  = DIR_UP;
                                pins_d = pins_q << 1;
                            end else begin
                                pins_d = pins_q >> 1;
                            end
                        end
                    end
                    default: pins_d = pins_q + LSB_HOT;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            dir_q  <= DIR_UP;
            mode_q <= bus.mode;
            pins_q <= seed(bus.mode);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            pins_q <= pins_d;
        end
    end

    assign bus.pins = pins_q;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: three 4-bit instances (DIV 3, 1, 2) against a step-count model
// plus directed literal expectations.
module tb_led_sequencer;
    localparam int W = 4;
    localparam int D[3] = '{3, 1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a[3];
    logic       en_a[3];
    logic [1:0] mode_a[3];
    logic [3:0] pins_a[3];
    logic       tick_a[3];

    led_sequencer_if #(.WIDTH(W)) if0 ();
    led_sequencer_if #(.WIDTH(W)) if1 ();
    led_sequencer_if #(.WIDTH(W)) if2 ();

    led_sequencer #(.WIDTH(W), .DIV(3)) dut0 (.clk(clk), .rst_n(rst_a[0]), .bus(if0));
    led_sequencer #(.WIDTH(W), .DIV(1)) dut1 (.clk(clk), .rst_n(rst_a[1]), .bus(if1));
    led_sequencer #(.WIDTH(W), .DIV(2)) dut2 (.clk(clk), .rst_n(rst_a[2]), .bus(if2));

    assign if0.en = en_a[0];  assign if0.mode = mode_a[0];
    assign if1.en = en_a[1];  assign if1.mode = mode_a[1];
    assign if2.en = en_a[2];  assign if2.mode = mode_a[2];
    assign pins_a[0] = if0.pins;  assign tick_a[0] = if0.tick;
    assign pins_a[1] = if1.pins;  assign tick_a[1] = if1.tick;
    assign pins_a[2] = if2.pins;  assign tick_a[2] = if2.tick;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pattern is a pure function of the mode and the number of steps taken since seeding.
    int         m_phase[3];
    int         m_cnt[3];
    bit         m_tick[3];
    logic [1:0] m_mode[3];
    bit         m_valid[3] = '{0, 0, 0};

    function automatic int model_pins(input logic [1:0] m, input int phase);
        int k;
        case (m)
            2'd0: return 1 << (phase % W);
            2'd1: return 1 << (W - 1 - (phase % W));
            2'd2: begin
                k = phase % (2 * (W - 1));
                return (k <= W - 1) ? (1 << k) : (1 << (2 * (W - 1) - k));
            end
            default: return phase % (1 << W);
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_a[i] || (m_valid[i] && mode_a[i] != m_mode[i])) begin
                m_valid[i] = 1'b1;
                m_mode[i]  = mode_a[i];
                m_phase[i] = 0;
                m_cnt[i]   = 0;
                m_tick[i]  = 1'b0;
            end else if (m_valid[i]) begin
                m_tick[i] = 1'b0;
                if (en_a[i]) begin
                    if (m_cnt[i] == D[i] - 1) begin
                        m_cnt[i]   = 0;
                        m_phase[i] = m_phase[i] + 1;
                        m_tick[i]  = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (m_valid[i]) begin
                chk($sformatf("model_pins[%0d]", i), pins_a[i], model_pins(m_mode[i], m_phase[i]));
                chk($sformatf("model_tick[%0d]", i), tick_a[i], m_tick[i]);
            end
        end
    end

    task automatic edge1();
        @(posedge clk);
        #2;
    endtask

    int exp_p0[12] = '{1, 1, 2, 2, 2, 4, 4, 4, 8, 8, 8, 1};
    int exp_t0[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int exp_p1[7]  = '{2, 4, 8, 4, 2, 1, 2};

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b0; en_a[i] = 1'b0; mode_a[i] = 2'd0;
        end
        fork
            begin
                mode_a[0] = 2'd1;
                for (int k = 0; k < 2; k++) begin
                    edge1();
                    chk("rst_seed_pins", pins_a[0], 8);
                    chk("rst_seed_tick", tick_a[0], 0);
                end
                mode_a[0] = 2'd0;
                edge1();
                chk("rst_seed_mode0", pins_a[0], 1);
                rst_a[0] = 1'b1; en_a[0] = 1'b1;
                for (int k = 0; k < 12; k++) begin
                    edge1();
                    chk($sformatf("rot_up_pins[%0d]", k), pins_a[0], exp_p0[k]);
                    chk($sformatf("rot_up_tick[%0d]", k), tick_a[0], exp_t0[k]);
                end
                for (int k = 0; k < 8; k++) edge1();
                chk("pre_switch_pins", pins_a[0], 4);
                mode_a[0] = 2'd1;
                edge1();
                chk("switch_pins", pins_a[0], 8);
                chk("switch_tick", tick_a[0], 0);
                edge1();
                edge1();
                chk("switch_hold_pins", pins_a[0], 8);
                chk("switch_hold_tick", tick_a[0], 0);
                edge1();
                chk("switch_step_pins", pins_a[0], 4);
                chk("switch_step_tick", tick_a[0], 1);
                edge1();
                edge1();
                rst_a[0] = 1'b0; mode_a[0] = 2'd2;
                edge1();
                chk("rst_prio_pins", pins_a[0], 1);
                chk("rst_prio_tick", tick_a[0], 0);
                edge1();
                chk("rst_hold_pins", pins_a[0], 1);
                rst_a[0] = 1'b1;
                edge1();
                edge1();
                edge1();
                chk("post_rst_step_pins", pins_a[0], 2);
                chk("post_rst_step_tick", tick_a[0], 1);
            end
            begin
                mode_a[1] = 2'd2; en_a[1] = 1'b1;
                edge1();
                chk("bounce_seed", pins_a[1], 1);
                rst_a[1] = 1'b1;
                for (int k = 0; k < 7; k++) begin
                    edge1();
                    chk($sformatf("bounce_pins[%0d]", k), pins_a[1], exp_p1[k]);
                    chk($sformatf("bounce_tick[%0d]", k), tick_a[1], 1);
                end
            end
            begin
                mode_a[2] = 2'd3; en_a[2] = 1'b1;
                edge1();
                chk("count_seed", pins_a[2], 0);
                rst_a[2] = 1'b1;
                for (int e = 1; e <= 32; e++) begin
                    edge1();
                    if (e == 30) begin
                        chk("count_15_pins", pins_a[2], 15);
                        chk("count_15_tick", tick_a[2], 1);
                    end else if (e == 31) begin
                        chk("count_15_hold", pins_a[2], 15);
                        chk("count_15_notick", tick_a[2], 0);
                    end else if (e == 32) begin
                        chk("count_wrap_pins", pins_a[2], 0);
                        chk("count_wrap_tick", tick_a[2], 1);
                    end
                end
                edge1();
                en_a[2] = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    edge1();
                    chk("en_hold_pins", pins_a[2], 0);
                    chk("en_hold_tick", tick_a[2], 0);
                end
                en_a[2] = 1'b1;
                edge1();
                chk("resume_pins", pins_a[2], 1);
                chk("resume_tick", tick_a[2], 1);
            end
        join
        edge1();
        edge1();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern generator for the board's output pins, and the successor to the fixed 18-LED one-hot chaser. A built-in prescaler divides the system clock into a step tick. On each tick the pattern register advances in one of four selectable modes: rotate up, rotate down, bounce, or binary count. The block sits directly between the oscillator clock and the top-level `pins` output, and provides enable, live mode switching and a tick strobe for other demo logic.

## Interface
- `WIDTH`, default 18: number of LED outputs; must be ≥ 2.
- `DIV`, default 500000: clock cycles per pattern step; must be ≥ 1. Prescaler width is max(1, clog2(DIV)).
- `clk` in 1: system clock, from the internal oscillator. Single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: step enable. 0 freezes the prescaler and the pattern.
- `mode` in 2: 0 = rotate up, 1 = rotate down, 2 = bounce, 3 = binary count.
- `pins` out WIDTH: current pattern, registered.
- `tick` out 1: one-cycle strobe, high in the cycle after the pattern advanced.

## Operation
- **Seed(mode):** modes 0 and 2 → 1 (bit 0 set); mode 1 → 1<<(WIDTH-1); mode 3 → 0.
- **Reset (`rst_n`=0 at an edge):**
  - `cnt` = 0, `tick` = 0, `dir` = up.
  - `mode_q` = `mode`, `pins` = seed(`mode`).
  - Reset overrides `en` and any mode change.
- **Mode change (`mode` ≠ `mode_q` at an edge, not in reset):**
  - `mode_q` ← `mode`, `pins` ← seed(`mode`), `cnt` ← 0, `dir` ← up, `tick` ← 0.
  - Applies regardless of `en`.
  - Takes priority over a step due on the same edge.
- **Prescaler (`en`=1, no mode change):**
  - If `cnt` = DIV-1: `cnt` ← 0, `tick` ← 1, and the pattern steps.
  - Otherwise: `cnt` ← `cnt`+1, `tick` ← 0.
- **`en`=0:** `cnt`, `pins` and `dir` hold; `tick` ← 0.
- **Step rules (P = `pins`):**
  - Mode 0: if P[WIDTH-1], then P ← 1; else P ← P<<1.
  - Mode 1: if P[0], then P ← 1<<(WIDTH-1); else P ← P>>1.
  - Mode 2, `dir` up: if P[WIDTH-1], then `dir` ← down and P ← P>>1; else P ← P<<1.
  - Mode 2, `dir` down: if P[0], then `dir` ← up and P ← P<<1; else P ← P>>1.
  - Mode 2 shows each endpoint once per sweep; period is 2·(WIDTH-1) steps.
  - Mode 3: P ← P+1, modulo 2^WIDTH; all-ones wraps to 0.
- **One-hot invariant:** P stays one-hot in modes 0–2, since these are only entered via seed.
- **`dir`:** ignored outside mode 2.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- First step after reset release or a mode change: on the DIV-th subsequent edge with `en`=1.
  - `pins` changes on that edge.
  - `tick` = 1 for exactly the following cycle.
- Steady state with `en`=1: one step every DIV cycles. DIV=1 steps every cycle, with `tick` held high continuously.
- Deasserting `en` mid-count preserves `cnt`. Counting resumes from the held value, so enabled cycles accumulate toward the step.
- Mode change: new seed is visible on `pins` the cycle after the edge where `mode` ≠ `mode_q`.
- Reset mid-operation: all state returns to reset values one edge after `rst_n` is sampled low. There is no partial step.

## Test plan
- **Reset seed:** WIDTH=4, DIV=3, `mode`=1 held, `rst_n` low for 2 edges.
  - `pins`=4'b1000 and `tick`=0 while in reset.
- **Rotate up and tick cadence:** WIDTH=4, DIV=3, `mode`=0, `en`=1 after reset.
  - `pins` goes 1→2→4→8→1, changing every 3 cycles.
  - `tick` is high exactly one cycle after each change and never otherwise.
- **Bounce:** WIDTH=4, DIV=1, `mode`=2.
  - Per-cycle `pins`: 1,2,4,8,4,2,1,2.
  - No endpoint is repeated.
- **Counter wrap and enable hold:** WIDTH=4, DIV=2, `mode`=3.
  - Count reaches 15, then 0.
  - Drop `en` for 5 cycles with `cnt`=1: `pins` and `tick` freeze.
  - Re-enable: next step happens on the first enabled edge.
- **Mode switch and reset priority:**
  - Mode switch: in mode 0 with `pins`=4, switch `mode` to 1 on the edge where a step is due. `pins`=8 next cycle, `tick`=0, and the next step comes DIV cycles later.
  - Reset priority: assert `rst_n`=0 on an edge with a mode change and a due step. Reset values win.
